// File: rtl/sync_fifo_core_if.sv
// sync_fifo_core_if: write/read handshake, data and status bundle
// for the single-clock FIFO.
// Ports: data_in/wr_en/rd_en (master drives), data_out, full,
//        almostfull, empty, almostempty, wr_ack, overflow,
//        underflow (slave drives).
interface sync_fifo_core_if #(
    parameter int FIFO_WIDTH = 16
);
    logic [FIFO_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  full;
    logic                  almostfull;
    logic                  empty;
    logic                  almostempty;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output data_in, wr_en, rd_en,
        input  data_out, full, almostfull, empty, almostempty,
        input  wr_ack, overflow, underflow
    );

    modport slave (
        input  data_in, wr_en, rd_en,
        output data_out, full, almostfull, empty, almostempty,
        output wr_ack, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_core.sv
// sync_fifo_core: single-clock FIFO with registered read data and
// registered wr_ack/overflow/underflow pulses.
// Ports: clk, rst_n (sync, active low), bus (sync_fifo_core_if.slave).
module sync_fifo_core #(
    parameter  int FIFO_WIDTH = 16,
    parameter  int FIFO_DEPTH = 8,
    localparam int ADDR_W     = $clog2(FIFO_DEPTH)
) (
    input logic              clk,
    input logic              rst_n,
    sync_fifo_core_if.slave  bus
);
    localparam int CW = ADDR_W + 1;

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [CW-1:0]         count;

    logic full;
    logic empty;
    logic wr_acc;
    logic rd_acc;

    assign full   = (count == CW'(FIFO_DEPTH));
    assign empty  = (count == '0);
    assign wr_acc = bus.wr_en & ~full;
    assign rd_acc = bus.rd_en & ~empty;

    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almostfull  = (count == CW'(FIFO_DEPTH - 1));
    assign bus.almostempty = (count == CW'(1));

    // Storage is deliberately not reset; pointers/count define validity.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            bus.data_out  <= '0;
            bus.wr_ack    <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            bus.wr_ack    <= wr_acc;
            bus.overflow  <= bus.wr_en & full;
            bus.underflow <= bus.rd_en & empty;

            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end

            // data_out holds when no read is accepted; a write into an
            // empty FIFO is never forwarded in the same cycle.
            if (rd_acc) begin
                bus.data_out <= mem[rd_ptr];
                rd_ptr       <= rd_ptr + ADDR_W'(1);
            end

            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: doc/sync_fifo_core.md
Name: sync_fifo_core

Overview:
Single-clock synchronous FIFO. It is the design under test whose pins the FIFO monitor samples on each negedge. It buffers write data, returns it in order on accepted reads, and raises status flags: full, almostfull, empty and almostempty. It also raises handshake/error pulses: wr_ack, overflow and underflow. All of these are consumed by the monitor, the scoreboard and the coverage collector.

Parameters:
FIFO_WIDTH, 16, data bit width
FIFO_DEPTH, 8, number of entries; must be a power of two, >= 4
ADDR_W, $clog2(FIFO_DEPTH), pointer width (derived, not overridden)

Ports:
clk  input  1  clock; all logic updates on posedge
rst_n  input  1  synchronous active-low reset, sampled on posedge clk
data_in  input  FIFO_WIDTH  write data
wr_en  input  1  write request
rd_en  input  1  read request
data_out  output  FIFO_WIDTH  read data, registered
full  output  1  count == FIFO_DEPTH
almostfull  output  1  count == FIFO_DEPTH-1
empty  output  1  count == 0
almostempty  output  1  count == 1
overflow  output  1  registered; write refused last cycle
underflow  output  1  registered; read refused last cycle
wr_ack  output  1  registered; write accepted last cycle

Behaviour:
- Storage and state:
  - Storage is mem[FIFO_DEPTH].
  - wr_ptr and rd_ptr are ADDR_W bits and wrap naturally from FIFO_DEPTH-1 to 0.
  - count is ADDR_W+1 bits, range 0..FIFO_DEPTH.
- Reset (rst_n=0 at posedge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - data_out=0, wr_ack=0, overflow=0, underflow=0.
  - mem is not cleared.
  - Resulting flags: empty=1, full=0, almostfull=0, almostempty=0.
  - Reset has priority over wr_en/rd_en in the same cycle.
  - Reset mid-operation discards all contents; the next read after reset sees empty.
- Write accept condition: wr_acc = wr_en & ~full.
  - On accept: mem[wr_ptr] <= data_in; wr_ptr++; wr_ack <= 1.
  - Otherwise: wr_ack <= 0.
  - overflow <= wr_en & full. It is a one-cycle pulse per refused write and is 0 otherwise.
- Read accept condition: rd_acc = rd_en & ~empty.
  - On accept: data_out <= mem[rd_ptr]; rd_ptr++.
  - Otherwise: data_out holds its previous value.
  - underflow <= rd_en & empty, with the same pulse semantics as overflow.
- Read latency: 1 cycle. Data is visible after the posedge that accepted rd_en, i.e. at the monitor's next negedge.
- Count update:
  - +1 if wr_acc & ~rd_acc.
  - -1 if rd_acc & ~wr_acc.
  - Unchanged if both or neither are accepted.
- Simultaneous wr_en & rd_en:
  - Not full and not empty: both accepted; count unchanged.
  - Full: read accepted, write refused (overflow=1, wr_ack=0); count goes to FIFO_DEPTH-1.
  - Empty: write accepted (wr_ack=1), read refused (underflow=1); count goes to 1. data_out does not pass through the written word.
- Flags:
  - full, almostfull, empty and almostempty are combinational decodes of count and are mutually exclusive for FIFO_DEPTH >= 4.
  - Flags reflect the state after the last posedge.
- No state machine beyond the pointer/count datapath. Ordering is strict FIFO across pointer wrap-around.

Test Plan:
1. Reset then idle: rst_n=0 for 2 cycles, then 1 -> empty=1, full=0, data_out=0, wr_ack=0, overflow=0, underflow=0.
2. Fill then overfill: write 0x0001..0x0008 on 8 consecutive cycles.
   - wr_ack=1 each cycle.
   - almostfull=1 after the 7th write; full=1 after the 8th.
   - A 9th write of 0xDEAD gives overflow=1, wr_ack=0, and count stays 8.
3. Drain then underflow: from full, read 8 times -> data_out=0x0001..0x0008 in order, each one cycle after its rd_en.
   - almostempty=1 after the 7th read; empty=1 after the 8th.
   - A 9th read gives underflow=1 and data_out holds 0x0008.
4. Wrap-around: write 5 words, read 5, then write 0xA000..0xA007 and read all 8 -> exact order preserved; pointers cross index 7→0 with no loss.
5. Simultaneous at boundaries:
   - Empty with wr_en=rd_en=1, data 0x1234 -> wr_ack=1, underflow=1, count=1, almostempty=1.
   - Full with wr_en=rd_en=1 -> overflow=1, oldest word on data_out, count=7, almostfull=1.
   - Half-full (count=4) with both -> count stays 4, wr_ack=1, no error flags.
6. Mid-operation reset: with count=5, assert rst_n=0 for one cycle while wr_en=1 -> write ignored; count=0, empty=1, data_out=0. The next rd_en gives underflow=1.
